aes_block_loader: RTL and testbench
===================================

// Module: aes_block_loader
// PURPOSE
//  Word-stream front/back end for the iterative AES-128 core. Assembles 32-bit input words into
//  128-bit key and plaintext registers, pulses the core start, waits for done, captures the cipher,
//  then returns the core to idle and streams the cipher out as four 32-bit words (valid/ready).
// PARAMETERS
//  WORD_W          32  stream word width; fixed, 128/WORD_W = 4 words per block
//  TIMEOUT_CYCLES  32  max cycles in WAIT for core_done before abort (>= 12)
// PORTS
//  clk          in   1    single clock, rising edge
//  reset_n      in   1    asynchronous, active-low reset
//  s_valid      in   1    input word valid
//  s_ready      out  1    input word accepted when s_valid & s_ready
//  s_key_sel    in   1    1: word is key material, 0: word is plaintext
//  s_data       in   32   input word; first word of a group -> bits [0:31]
//  core_start   out  1    one-cycle start pulse to core
//  core_key     out  128  assembled key, stable from START until CLEAR
//  core_data    out  128  assembled plaintext, stable from START until CLEAR
//  core_done    in   1    core done (level; held until core is cleared)
//  core_cipher  in   128  core cipher, valid while core_done=1
//  core_clear_n out  1    one-cycle active-low core return-to-idle; top ANDs it into core reset_n
//  m_valid      out  1    output word valid
//  m_ready      in   1    output word taken when m_valid & m_ready
//  m_data       out  32   cipher word; word 0 = bits [0:31]
//  m_last       out  1    high with 4th cipher word
//  err_timeout  out  1    sticky: WAIT exceeded TIMEOUT_CYCLES
//  err_overrun  out  1    sticky: plaintext word dropped (data regs full, no key)
// BEHAVIOUR
//  Reset: state=COLLECT, counters/key_valid/regs=0; outputs 0 except core_clear_n=1, s_ready=1.
//  States: COLLECT -> START -> WAIT -> CLEAR -> SEND -> COLLECT; WAIT --timeout--> CLEAR(abort) -> COLLECT.
//  COLLECT: s_ready=1. Key word -> key reg slot key_cnt, key_cnt++ (2b wrap); key_valid set on 4th.
//   A key word with key_valid=1 clears key_valid and restarts at slot 0 (new key).
//   Data word -> slot data_cnt, data_cnt++; data_full on 4th. Data word while data_full: dropped,
//   err_overrun<=1. Leave to START the cycle after data_full & key_valid both true.
//  START: core_start=1 for exactly one cycle; timeout counter cleared; -> WAIT.
//  WAIT: s_ready=0. core_done=1 -> capture core_cipher into out reg, -> CLEAR. Counter reaches
//   TIMEOUT_CYCLES first -> err_timeout<=1, abort flag set, -> CLEAR. core_done in START ignored.
//  CLEAR: core_clear_n=0 one cycle; data_cnt/data_full cleared; -> SEND, or COLLECT if aborted.
//  SEND: m_valid=1, m_data=word[out_cnt]; advance on m_ready; m_last when out_cnt=3; after the
//   3rd->last handshake -> COLLECT. m_valid held while m_ready=0; m_data stable. s_ready=0.
//  Latency: last input word accepted at cycle N -> core_start at N+1 (N+2 if key completed at N);
//   core_done seen at D -> core_clear_n low D+1 -> first m_valid D+2.
//  Errors cleared only by reset. Reset mid-op: immediate return to reset state; partial words lost.
// CONFIGURATION
//  AES_KEY_CACHE_EN defined: key_valid survives CLEAR; successive blocks need only 4 data words.
//  Not defined: key_valid and key_cnt cleared in CLEAR; every block needs 4 fresh key words.
// STRUCTURE
//  aes_pkg: state encoding (COLLECT..SEND), AES_BLOCK_W=128, WORDS_PER_BLOCK=4, word-slice function.
//  Sub-module aes_cipher_serializer: 128-bit capture reg + out_cnt + m_* handshake (SEND side).
// TESTING
//  FIPS-197: key 000102..0e0f, pt 00112233..eeff -> m_data 69c4e0d8,6a7b0430,d8cdb780,70b4c55a, m_last on 4th.
//  Backpressure: m_ready low 5 cycles per word -> m_valid/m_data held, exactly 4 handshakes.
//  Key cache: 2nd block 4 data words only -> with _EN core_start fires; without, no start until 4 key words.
//  Timeout: core_done tied 0 -> err_timeout=1 after 32 WAIT cycles, core_clear_n pulse, no m_valid.
//  Overrun: 5th data word without key -> err_overrun=1, data regs unchanged.
//  Reset in WAIT and in SEND (after 2 words) -> all outputs to reset values, next vector encrypts correctly.

Source files
------------

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared state encoding, block geometry and word-slice helpers for the AES block loader
// Contents:
//   state_t         loader FSM states COLLECT, START, WAIT, CLEAR, SEND
//   AES_BLOCK_W     128-bit block width
//   WORDS_PER_BLOCK stream words per block
//   slot_lsb()      LSB position of word slot idx inside a block
//   word_slice()    extract word idx from a block
package aes_pkg;

   typedef enum logic [2:0] {
      ST_COLLECT,
      ST_START,
      ST_WAIT,
      ST_CLEAR,
      ST_SEND
   } state_t;

   localparam int AES_BLOCK_W     = 128;
   localparam int WORDS_PER_BLOCK = 4;
   localparam int AES_WORD_W      = AES_BLOCK_W / WORDS_PER_BLOCK;

   // Block bits are numbered FIPS-style: word 0 is bits [0:31], which are the MSBs.
   function automatic int slot_lsb(input logic [1:0] idx);
      return AES_WORD_W * (WORDS_PER_BLOCK - 1 - int'(idx));
   endfunction

   function automatic logic [AES_WORD_W-1:0] word_slice(input logic [AES_BLOCK_W-1:0] blk,
                                                        input logic [1:0]             idx);
      return blk[slot_lsb(idx) +: AES_WORD_W];
   endfunction

endpackage

// File: rtl/aes_cipher_serializer.sv
// rtl/aes_cipher_serializer.sv - captures the 128-bit cipher and streams it out as four words
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   load, cipher   capture cipher and rewind the word counter
//   send_en        present words on the m_* stream
//   m_valid/m_ready/m_data/m_last  output word stream
//   last_hs        handshake of the final word this cycle
module aes_cipher_serializer
   import aes_pkg::*;
(
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   load,
   input  logic [AES_BLOCK_W-1:0] cipher,
   input  logic                   send_en,
   input  logic                   m_ready,
   output logic                   m_valid,
   output logic [AES_WORD_W-1:0]  m_data,
   output logic                   m_last,
   output logic                   last_hs
);

   logic [AES_BLOCK_W-1:0] cipher_q;
   logic [1:0]             out_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cipher_q <= '0;
         out_cnt  <= '0;
      end else if (load) begin
         cipher_q <= cipher;
         out_cnt  <= '0;
      end else if (m_valid && m_ready) begin
         out_cnt  <= out_cnt + 2'd1;
      end
   end

   assign m_valid = send_en;
   // Gate data so the stream reads zero whenever no word is offered.
   assign m_data  = m_valid ? word_slice(cipher_q, out_cnt) : '0;
   assign m_last  = m_valid && (out_cnt == 2'd3);
   assign last_hs = m_last && m_ready;

endmodule

// File: rtl/aes_block_loader.sv
// rtl/aes_block_loader.sv - word-stream front/back end for the iterative AES-128 core
// Optional feature macro: AES_KEY_CACHE_EN (key stays valid across blocks).
// Ports:
//   clk, reset_n                        clock, asynchronous active-low reset
//   s_valid/s_ready/s_key_sel/s_data    input words (key or plaintext)
//   core_start, core_key, core_data     start pulse and assembled operands to the core
//   core_done, core_cipher              core completion level and result
//   core_clear_n                        one-cycle active-low core return-to-idle
//   m_valid/m_ready/m_data/m_last       cipher output words
//   err_timeout, err_overrun            sticky error flags, cleared by reset only
module aes_block_loader
   import aes_pkg::*;
#(
   parameter int WORD_W         = 32,
   parameter int TIMEOUT_CYCLES = 32
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   s_valid,
   output logic                   s_ready,
   input  logic                   s_key_sel,
   input  logic [WORD_W-1:0]      s_data,
   output logic                   core_start,
   output logic [AES_BLOCK_W-1:0] core_key,
   output logic [AES_BLOCK_W-1:0] core_data,
   input  logic                   core_done,
   input  logic [AES_BLOCK_W-1:0] core_cipher,
   output logic                   core_clear_n,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [WORD_W-1:0]      m_data,
   output logic                   m_last,
   output logic                   err_timeout,
   output logic                   err_overrun
);

   localparam int TW = $clog2(TIMEOUT_CYCLES);

   state_t                 state_q, state_d;
   logic [AES_BLOCK_W-1:0] key_q, data_q;
   logic [1:0]             key_cnt, data_cnt;
   logic                   key_valid, data_full;
   logic [TW-1:0]          tmo_cnt;
   logic                   abort_q, err_to_q, err_ov_q;
   logic                   load, send_en, last_hs;
   logic                   accept, data_last, tmo_hit;

   assign accept    = s_valid && s_ready;
   assign data_last = accept && !s_key_sel && !data_full && (data_cnt == 2'd3);
   assign tmo_hit   = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

   always_comb begin
      state_d      = state_q;
      s_ready      = 1'b0;
      core_start   = 1'b0;
      core_clear_n = 1'b1;
      send_en      = 1'b0;
      load         = 1'b0;
      case (state_q)
         ST_COLLECT: begin
            // Refuse words in the one cycle where both halves are complete and we are leaving.
            s_ready = !(key_valid && data_full);
            if ((key_valid && data_full) || (key_valid && data_last))
               state_d = ST_START;
         end
         ST_START: begin
            core_start = 1'b1;
            state_d    = ST_WAIT;
         end
         ST_WAIT: begin
            if (core_done) begin
               load    = 1'b1;
               state_d = ST_CLEAR;
            end else if (tmo_hit) begin
               state_d = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            core_clear_n = 1'b0;
            state_d      = abort_q ? ST_COLLECT : ST_SEND;
         end
         ST_SEND: begin
            send_en = 1'b1;
            if (last_hs)
               state_d = ST_COLLECT;
         end
         default: state_d = ST_COLLECT;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_COLLECT;
         key_q     <= '0;
         data_q    <= '0;
         key_cnt   <= '0;
         data_cnt  <= '0;
         key_valid <= 1'b0;
         data_full <= 1'b0;
         tmo_cnt   <= '0;
         abort_q   <= 1'b0;
         err_to_q  <= 1'b0;
         err_ov_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            if (s_key_sel) begin
               if (key_valid) begin
                  // A key word on top of a complete key begins a fresh key.
                  key_q[slot_lsb(2'd0) +: AES_WORD_W] <= s_data;
                  key_cnt   <= 2'd1;
                  key_valid <= 1'b0;
               end else begin
                  key_q[slot_lsb(key_cnt) +: AES_WORD_W] <= s_data;
                  key_cnt <= key_cnt + 2'd1;
                  if (key_cnt == 2'd3)
                     key_valid <= 1'b1;
               end
            end else if (data_full) begin
               err_ov_q <= 1'b1;
            end else begin
               data_q[slot_lsb(data_cnt) +: AES_WORD_W] <= s_data;
               data_cnt <= data_cnt + 2'd1;
               if (data_cnt == 2'd3)
                  data_full <= 1'b1;
            end
         end
         if (state_q == ST_START)
            tmo_cnt <= '0;
         else if (state_q == ST_WAIT)
            tmo_cnt <= tmo_cnt + 1'b1;
         if (state_q == ST_WAIT && !core_done && tmo_hit) begin
            err_to_q <= 1'b1;
            abort_q  <= 1'b1;
         end
         if (state_q == ST_CLEAR) begin
            abort_q   <= 1'b0;
            data_cnt  <= '0;
            data_full <= 1'b0;
`ifdef AES_KEY_CACHE_EN
`else
            key_valid <= 1'b0;
            key_cnt   <= '0;
`endif
         end
      end
   end

   assign core_key    = key_q;
   assign core_data   = data_q;
   assign err_timeout = err_to_q;
   assign err_overrun = err_ov_q;

   aes_cipher_serializer u_ser (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (load),
      .cipher  (core_cipher),
      .send_en (send_en),
      .m_ready (m_ready),
      .m_valid (m_valid),
      .m_data  (m_data),
      .m_last  (m_last),
      .last_hs (last_hs)
   );

endmodule

// File: tb/tb_aes_block_loader.sv
// tb/tb_aes_block_loader.sv - scoreboard bench for aes_block_loader with a behavioural core stand-in
module tb_aes_block_loader;

   localparam int TMO = 32;
   localparam logic [127:0] FIPS_K = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] FIPS_P = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] FIPS_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         s_valid = 1'b0, s_ready, s_key_sel = 1'b0;
   logic [31:0]  s_data = '0;
   logic         core_start, core_done, core_clear_n;
   logic [127:0] core_key, core_data, core_cipher;
   logic         m_valid, m_ready, m_last;
   logic [31:0]  m_data;
   logic         err_timeout, err_overrun;

   always #5 clk = ~clk;

   aes_block_loader #(.WORD_W(32), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .reset_n(reset_n),
      .s_valid(s_valid), .s_ready(s_ready), .s_key_sel(s_key_sel), .s_data(s_data),
      .core_start(core_start), .core_key(core_key), .core_data(core_data),
      .core_done(core_done), .core_cipher(core_cipher), .core_clear_n(core_clear_n),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
      .err_timeout(err_timeout), .err_overrun(err_overrun)
   );

   int total = 0, bad = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Stand-in for the AES core: FIPS vector returns the real cipher, anything else a keyed mix.
   function automatic logic [127:0] fake_aes(input logic [127:0] k, input logic [127:0] d);
      if (k == FIPS_K && d == FIPS_P) return FIPS_C;
      return k ^ {d[63:0], d[127:64]} ^ 128'h5a5a_a5a5_0f0f_f0f0_3c3c_c3c3_1234_8765;
   endfunction

   logic         hang = 1'b0;
   int           core_lat = 3;
   logic [127:0] ck, cd;
   int           cdown;
   logic         cbusy;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         core_done <= 1'b0; core_cipher <= '0; cbusy <= 1'b0; cdown <= 0; ck <= '0; cd <= '0;
      end else if (!core_clear_n) begin
         core_done <= 1'b0; cbusy <= 1'b0;
      end else if (core_start) begin
         cbusy <= 1'b1; cdown <= core_lat; ck <= core_key; cd <= core_data;
      end else if (cbusy && !hang && !core_done) begin
         if (cdown <= 1) begin
            core_done <= 1'b1; core_cipher <= fake_aes(ck, cd);
         end else begin
            cdown <= cdown - 1;
         end
      end
   end

   // Reference model: words collected in arrival order, first word is the block MSB word.
   logic [31:0]  mk[$], md[$];
   logic         mk_ok = 1'b0;
   logic [31:0]  exp_w[$];
   logic         exp_l[$];
   int           exp_sc[$];
   logic [127:0] exp_k[$], exp_d[$];
   int           exp_starts = 0;

   function automatic logic [127:0] pack4(input logic [31:0] a, b, c, d);
      return {a, b, c, d};
   endfunction

   task automatic model_fire(input int sc);
      logic [127:0] k, d, c;
      if (!(mk_ok && md.size() == 4)) return;
      k = pack4(mk[0], mk[1], mk[2], mk[3]);
      d = pack4(md[0], md[1], md[2], md[3]);
      exp_sc.push_back(sc); exp_k.push_back(k); exp_d.push_back(d);
      exp_starts++;
      if (!hang) begin
         c = fake_aes(k, d);
         exp_w.push_back(c[127:96]); exp_l.push_back(1'b0);
         exp_w.push_back(c[95:64]);  exp_l.push_back(1'b0);
         exp_w.push_back(c[63:32]);  exp_l.push_back(1'b0);
         exp_w.push_back(c[31:0]);   exp_l.push_back(1'b1);
      end
      md.delete();
`ifndef AES_KEY_CACHE_EN
      mk.delete(); mk_ok = 1'b0;
`endif
   endtask

   task automatic model_word(input logic sel, input logic [31:0] w, input int acc);
      if (sel) begin
         if (mk_ok) begin mk.delete(); mk_ok = 1'b0; end
         mk.push_back(w);
         if (mk.size() == 4) begin mk_ok = 1'b1; model_fire(acc + 2); end
      end else if (md.size() < 4) begin
         md.push_back(w);
         if (md.size() == 4) model_fire(acc + 1);
      end
   endtask

   task automatic send_word(input logic sel, input logic [31:0] w);
      int n = 0;
      @(negedge clk);
      s_valid = 1'b1; s_key_sel = sel; s_data = w;
      while (!s_ready && n < 400) begin @(negedge clk); n++; end
      if (!s_ready) begin
         check("s_ready_wait", 0, 1);
         s_valid = 1'b0;
         return;
      end
      model_word(sel, w, cyc);
      @(posedge clk); #1;
      s_valid = 1'b0;
   endtask

   task automatic send_block(input logic [127:0] v, input logic sel);
      send_word(sel, v[127:96]); send_word(sel, v[95:64]);
      send_word(sel, v[63:32]);  send_word(sel, v[31:0]);
   endtask

   // Output side: m_ready pattern chosen by rmode (0 always, 1 random, 2 five low per word).
   int rmode = 0;
   int rcnt = 0;
   initial begin
      m_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         case (rmode)
            0: m_ready = 1'b1;
            1: m_ready = 1'($urandom_range(0, 1));
            default: begin
               if (!m_valid) begin rcnt = 0; m_ready = 1'b0; end
               else if (rcnt == 5) begin rcnt = 0; m_ready = 1'b1; end
               else begin rcnt++; m_ready = 1'b0; end
            end
         endcase
      end
   end

   int           starts = 0, hs_blk = 0, hs_total = 0, start_at = 0, done_cyc = 0;
   logic         done_seen = 1'b0, mv_seen = 1'b0, prev_stall = 1'b0;
   logic [31:0]  prev_data = '0;

   initial begin
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            prev_stall = 1'b0;
         end else begin
            if (core_start) begin
               starts++; hs_blk = 0; done_seen = 1'b0; mv_seen = 1'b0; start_at = cyc;
               if (exp_sc.size() == 0) check("unexpected_start", 1, 0);
               else begin
                  check("start_latency", cyc, exp_sc.pop_front());
                  check("core_key", core_key, exp_k.pop_front());
                  check("core_data", core_data, exp_d.pop_front());
               end
            end
            if (core_done && !done_seen) begin done_seen = 1'b1; done_cyc = cyc; end
            if (!core_clear_n && done_seen) check("clear_latency", cyc - done_cyc, 1);
            if (m_valid && !mv_seen) begin
               mv_seen = 1'b1;
               check("mvalid_latency", cyc - done_cyc, 2);
            end
            if (prev_stall) begin
               check("hold_valid", m_valid, 1);
               check("hold_data", m_data, prev_data);
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            if (m_valid && m_ready) begin
               hs_blk++; hs_total++;
               if (exp_w.size() == 0) check("unexpected_word", m_data, 0);
               else begin
                  check("m_data", m_data, exp_w.pop_front());
                  check("m_last", m_last, exp_l.pop_front());
               end
            end
         end
      end
   end

   task automatic do_reset();
      reset_n = 1'b0; s_valid = 1'b0;
      mk.delete(); md.delete(); mk_ok = 1'b0;
      exp_w.delete(); exp_l.delete(); exp_sc.delete(); exp_k.delete(); exp_d.delete();
      repeat (3) @(negedge clk);
      check("rst_s_ready", s_ready, 1);
      check("rst_core_start", core_start, 0);
      check("rst_core_clear_n", core_clear_n, 1);
      check("rst_m_valid", m_valid, 0);
      check("rst_m_data", m_data, 0);
      check("rst_m_last", m_last, 0);
      check("rst_err_timeout", err_timeout, 0);
      check("rst_err_overrun", err_overrun, 0);
      check("rst_core_key", core_key, 0);
      check("rst_core_data", core_data, 0);
      reset_n = 1'b1;
      exp_starts = starts;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while ((exp_w.size() != 0 || exp_sc.size() != 0 || !s_ready) && n < 600) begin
         @(negedge clk); n++;
      end
      check(name, exp_w.size() + exp_sc.size(), 0);
      repeat (3) @(negedge clk);
   endtask

   task automatic wait_start_count(input int target);
      int n = 0;
      while (starts < target && n < 200) begin @(negedge clk); n++; end
      check("start_seen", starts >= target, 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want completion");
      bad++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      logic [127:0] kv, dv;
      int hsb, n, ki, di;
      do_reset();

      // FIPS-197 vector, key first so the data word completes the block.
      core_lat = 4;
      send_block(FIPS_K, 1'b1);
      send_block(FIPS_P, 1'b0);
      drain("fips_drain");

      // Backpressure: five low m_ready cycles before each word.
      rmode = 2; hsb = hs_total;
      send_block(FIPS_K, 1'b1);
      send_block(FIPS_P, 1'b0);
      drain("bp_drain");
      check("bp_handshakes", hs_total - hsb, 4);
      rmode = 0;

      // Randomized blocks with interleaved key/data words and random output stalls.
      for (int b = 0; b < 8; b++) begin
         kv = {$urandom, $urandom, $urandom, $urandom};
         dv = {$urandom, $urandom, $urandom, $urandom};
         core_lat = $urandom_range(1, 10);
         rmode = $urandom_range(0, 1);
         ki = 0; di = 0;
         while (ki < 4 || di < 4) begin
            if (di == 4 || (ki < 4 && $urandom_range(0, 1) == 1)) begin
               send_word(1'b1, kv[127 - 32*ki -: 32]); ki++;
            end else begin
               send_word(1'b0, dv[127 - 32*di -: 32]); di++;
            end
         end
         drain("rand_drain");
      end
      rmode = 0;

      // Key cache: second block with data words only.
      do_reset();
      send_block(FIPS_K, 1'b1);
      send_block(FIPS_P, 1'b0);
      drain("cache_blk1");
      dv = {$urandom, $urandom, $urandom, $urandom};
      send_block(dv, 1'b0);
      repeat (40) @(negedge clk);
      check("cache_starts", starts, exp_starts);
      kv = {$urandom, $urandom, $urandom, $urandom};
      send_block(kv, 1'b1);
      drain("cache_blk2");
      check("cache_starts2", starts, exp_starts);

      // Overrun: fifth plaintext word with no key is dropped.
      do_reset();
      dv = {$urandom, $urandom, $urandom, $urandom};
      send_block(dv, 1'b0);
      send_word(1'b0, 32'hdead_beef);
      repeat (2) @(negedge clk);
      check("overrun_flag", err_overrun, 1);
      check("overrun_data", core_data, dv);
      send_block(FIPS_K, 1'b1);
      drain("overrun_drain");

      // Timeout: core never answers.
      do_reset();
      hang = 1'b1; hsb = hs_total;
      send_block(FIPS_K, 1'b1);
      send_block(FIPS_P, 1'b0);
      n = 0;
      while (!err_timeout && n < 200) begin @(negedge clk); n++; end
      check("timeout_flag", err_timeout, 1);
      check("timeout_cycles", cyc - start_at, TMO + 1);
      check("timeout_clear_pulse", core_clear_n, 0);
      drain("timeout_drain");
      check("timeout_no_output", hs_total - hsb, 0);
      hang = 1'b0;
      core_lat = 2;
      send_block(FIPS_K, 1'b1);
      send_block(FIPS_P, 1'b0);
      drain("post_timeout_drain");
      check("timeout_sticky", err_timeout, 1);

      // Reset while waiting for the core.
      core_lat = 25;
      n = starts;
      send_block(FIPS_K, 1'b1);
      send_block(FIPS_P, 1'b0);
      wait_start_count(n + 1);
      repeat (3) @(negedge clk);
      #2;
      do_reset();
      core_lat = 3;
      send_block(FIPS_K, 1'b1);
      send_block(FIPS_P, 1'b0);
      drain("after_wait_reset");

      // Reset after two output words.
      rmode = 0;
      n = starts;
      send_block(FIPS_K, 1'b1);
      send_block(FIPS_P, 1'b0);
      wait_start_count(n + 1);
      n = 0;
      while (hs_blk < 2 && n < 200) begin @(posedge clk); #2; n++; end
      check("send_two_words", hs_blk, 2);
      do_reset();
      send_block(FIPS_K, 1'b1);
      send_block(FIPS_P, 1'b0);
      drain("after_send_reset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
